// File: rtl/i2c_target_sync.sv
// Oversampled I2C target: synchronizes SCL/SDA to clk, detects START/STOP, matches a
// fixed 7-bit address and bridges write/read bytes to a one-byte stream interface.
module i2c_target_sync #(
  parameter logic [6:0]  TARGET_ADDR = 7'h01,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy,
  output logic       stop_det,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_WRITE     = 3'd3,
    S_WRITE_ACK = 3'd4,
    S_READ      = 3'd5,
    S_READ_ACK  = 3'd6,
    S_WAIT_STOP = 3'd7
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_shift;
  logic [6:0]             r_tx_shift;
  logic                   r_rw;
  logic                   r_byte_done;

  logic       w_scl_s;
  logic       w_sda_s;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_shift_next;

  // Synchronizers idle high so reset never fabricates a bus edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_prev <= w_scl_s;
      r_sda_prev <= w_sda_s;
    end
  end

  assign w_scl_s      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise   = w_scl_s & ~r_scl_prev;
  assign w_scl_fall   = ~w_scl_s & r_scl_prev;
  assign w_start      = w_scl_s & r_sda_prev & ~w_sda_s;
  assign w_stop       = w_scl_s & ~r_sda_prev & w_sda_s;
  assign w_shift_next = {r_shift, w_sda_s};
  assign dbg_state    = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      r_tx_shift  <= 7'd0;
      r_rw        <= 1'b0;
      r_byte_done <= 1'b0;
      sda_oe      <= 1'b0;
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      tx_load     <= 1'b0;
      busy        <= 1'b0;
      stop_det    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      stop_det <= 1'b0;
      if (w_stop) begin
        r_state     <= S_IDLE;
        r_bit_cnt   <= 3'd0;
        r_byte_done <= 1'b0;
        sda_oe      <= 1'b0;
        busy        <= 1'b0;
        stop_det    <= 1'b1;
      end else if (w_start) begin
        // Repeated start: busy is left alone until the next address decision.
        r_state     <= S_ADDR;
        r_bit_cnt   <= 3'd0;
        r_byte_done <= 1'b0;
        sda_oe      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: sda_oe <= 1'b0;
          S_ADDR: begin
            if (w_scl_rise && !r_byte_done) begin
              r_shift   <= w_shift_next[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (w_shift_next[7:1] == TARGET_ADDR) begin
                  r_rw        <= w_shift_next[0];
                  r_byte_done <= 1'b1;
                end else begin
                  r_state <= S_WAIT_STOP;
                  busy    <= 1'b0;
                end
              end
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              sda_oe      <= 1'b1;
              busy        <= 1'b1;
              r_state     <= S_ADDR_ACK;
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 3'd0;
              if (!r_rw) begin
                sda_oe  <= 1'b0;
                r_state <= S_WRITE;
              end else begin
                tx_load    <= 1'b1;
                r_tx_shift <= tx_data[6:0];
                sda_oe     <= ~tx_data[7];
                r_state    <= S_READ;
              end
            end
          end
          S_WRITE: begin
            if (w_scl_rise && !r_byte_done) begin
              r_shift   <= w_shift_next[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                rx_data     <= w_shift_next;
                rx_valid    <= 1'b1;
                r_byte_done <= 1'b1;
              end
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              sda_oe      <= 1'b1;
              r_state     <= S_WRITE_ACK;
            end
          end
          S_WRITE_ACK: begin
            if (w_scl_fall) begin
              sda_oe    <= 1'b0;
              r_bit_cnt <= 3'd0;
              r_state   <= S_WRITE;
            end
          end
          S_READ: begin
            // Bit 7 went out on entry; each fall presents the next bit, then releases for the ACK.
            if (w_scl_fall) begin
              if (r_bit_cnt == 3'd7) begin
                sda_oe    <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_state   <= S_READ_ACK;
              end else begin
                sda_oe     <= ~r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
              end
            end
          end
          S_READ_ACK: begin
            if (w_scl_rise && !r_byte_done) begin
              if (w_sda_s) begin
                r_state <= S_WAIT_STOP;
                busy    <= 1'b0;
              end else begin
                r_byte_done <= 1'b1;
              end
            end else if (w_scl_fall && r_byte_done) begin
              r_byte_done <= 1'b0;
              tx_load     <= 1'b1;
              r_tx_shift  <= tx_data[6:0];
              sda_oe      <= ~tx_data[7];
              r_bit_cnt   <= 3'd0;
              r_state     <= S_READ;
            end
          end
          S_WAIT_STOP: sda_oe <= 1'b0;
          default: begin
            r_state <= S_IDLE;
            sda_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_sync.sv
// Bench for i2c_target_sync: a bit-level I2C master on a wired-AND SDA, with
// scoreboards for written bytes (rx) and bytes read back over the bus.
module tb_i2c_target_sync;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_load;
  logic       busy;
  logic       stop_det;
  logic [2:0] dbg_state;

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int txl_cnt = 0;
  int stop_cnt = 0;
  logic oe_seen = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_rd_q[$];

  always #5 clk = ~clk;

  assign sda_bus = m_sda & ~sda_oe;

  i2c_target_sync #(.TARGET_ADDR(7'h01), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_load(tx_load),
    .busy(busy), .stop_det(stop_det), .dbg_state(dbg_state)
  );

  // Monitors sample on the falling clock edge, away from DUT updates.
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (tx_load) txl_cnt++;
    if (stop_det) stop_cnt++;
    if (rx_valid) begin
      rx_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rx_unexpected: got %02h want none", rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          bad++;
          $display("FAIL rx_data: got %02h want %02h", rx_data, e);
        end
      end
    end
  end

  task automatic w(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    w(5); m_sda = b;
    w(5); scl = 1'b1;
    w(5); r = sda_bus;
    w(5); scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      w(5); m_sda = 1'b1;
      w(5); scl = 1'b1;
      w(5);
    end
    m_sda = 1'b0;
    w(10); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    w(5); m_sda = 1'b0;
    w(5); scl = 1'b1;
    w(10); m_sda = 1'b1;
    w(10);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, r);
    acked = (r == 1'b0);
  endtask

  task automatic read_byte(input logic nack);
    logic [7:0] d;
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, r);
      d[i] = r;
    end
    i2c_bit(nack, r);
    total++;
    if (r !== nack) begin
      bad++;
      $display("FAIL rd_ack_bit: got %0b want %0b", r, nack);
    end
    total++;
    if (exp_rd_q.size() == 0) begin
      bad++;
      $display("FAIL rd_unexpected: got %02h want none", d);
    end else begin
      logic [7:0] e;
      e = exp_rd_q.pop_front();
      if (d !== e) begin
        bad++;
        $display("FAIL rd_data: got %02h want %02h", d, e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    w(3);
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_sda_oe: got %0b want 0", sda_oe); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx_data: got %02h want 00", rx_data); end
    total++; if ({rx_valid, tx_load, stop_det} !== 3'b000) begin bad++; $display("FAIL rst_pulses: got %03b want 000", {rx_valid, tx_load, stop_det}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    rst_n = 1'b1;
    w(6);
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_write_single();
    logic a;
    int rx0, st0;
    rx0 = rx_cnt; st0 = stop_cnt;
    exp_q.push_back(8'hAA);
    i2c_start();
    write_byte(8'h02, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL ws_addr_ack: got %0b want 1", a); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ws_busy: got %0b want 1", busy); end
    write_byte(8'hAA, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL ws_data_ack: got %0b want 1", a); end
    i2c_stop();
    total++; if (rx_data !== 8'hAA) begin bad++; $display("FAIL ws_rx_data: got %02h want aa", rx_data); end
    total++; if (rx_cnt - rx0 !== 1) begin bad++; $display("FAIL ws_rx_cnt: got %0d want 1", rx_cnt - rx0); end
    total++; if (stop_cnt - st0 !== 1) begin bad++; $display("FAIL ws_stop_cnt: got %0d want 1", stop_cnt - st0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ws_busy_end: got %0b want 0", busy); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL ws_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_addr_mismatch();
    logic a;
    int rx0;
    rx0 = rx_cnt;
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'h04, a);
    total++; if (a !== 1'b0) begin bad++; $display("FAIL mm_addr_ack: got %0b want 0", a); end
    write_byte(8'h55, a);
    total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL mm_sda_oe: got %0b want 0", oe_seen); end
    total++; if (dbg_state !== ST_WAIT_STOP) begin bad++; $display("FAIL mm_state: got %0d want %0d", dbg_state, ST_WAIT_STOP); end
    total++; if (rx_cnt - rx0 !== 0) begin bad++; $display("FAIL mm_rx_cnt: got %0d want 0", rx_cnt - rx0); end
    i2c_stop();
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL mm_state_end: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_read_nack();
    logic a;
    int tl0;
    tl0 = txl_cnt;
    tx_data = 8'h0F;
    exp_rd_q.push_back(8'h0F);
    i2c_start();
    write_byte(8'h03, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL rn_addr_ack: got %0b want 1", a); end
    read_byte(1'b1);
    w(5);
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rn_sda_oe: got %0b want 0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rn_busy: got %0b want 0", busy); end
    total++; if (dbg_state !== ST_WAIT_STOP) begin bad++; $display("FAIL rn_state: got %0d want %0d", dbg_state, ST_WAIT_STOP); end
    total++; if (txl_cnt - tl0 !== 1) begin bad++; $display("FAIL rn_tx_load: got %0d want 1", txl_cnt - tl0); end
    i2c_stop();
  endtask

  task automatic test_back_to_back();
    logic a;
    int rx0;
    rx0 = rx_cnt;
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h0F);
    i2c_start();
    write_byte(8'h02, a);
    write_byte(8'hAA, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL bb_ack0: got %0b want 1", a); end
    write_byte(8'h0F, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL bb_ack1: got %0b want 1", a); end
    i2c_stop();
    total++; if (rx_cnt - rx0 !== 2) begin bad++; $display("FAIL bb_rx_cnt: got %0d want 2", rx_cnt - rx0); end
    total++; if (rx_data !== 8'h0F) begin bad++; $display("FAIL bb_rx_data: got %02h want 0f", rx_data); end
  endtask

  task automatic test_restart_read();
    logic a;
    int tl0;
    tl0 = txl_cnt;
    exp_q.push_back(8'h55);
    tx_data = 8'hC3;
    exp_rd_q.push_back(8'hC3);
    exp_rd_q.push_back(8'hC3);
    i2c_start();
    write_byte(8'h02, a);
    write_byte(8'h55, a);
    i2c_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rs_busy_hold: got %0b want 1", busy); end
    write_byte(8'h03, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL rs_addr_ack: got %0b want 1", a); end
    read_byte(1'b0);
    read_byte(1'b1);
    i2c_stop();
    total++; if (rx_data !== 8'h55) begin bad++; $display("FAIL rs_rx_data: got %02h want 55", rx_data); end
    total++; if (txl_cnt - tl0 !== 2) begin bad++; $display("FAIL rs_tx_load: got %0d want 2", txl_cnt - tl0); end
  endtask

  task automatic test_reset_mid();
    logic a, r;
    int rx0, st0;
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'h02, a);
    i2c_bit(1'b1, r);
    i2c_bit(1'b0, r);
    i2c_bit(1'b1, r);
    w(5); m_sda = 1'b0;
    w(5); scl = 1'b1;
    w(3); rst_n = 1'b0;
    #1;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rm_sda_oe: got %0b want 0", sda_oe); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %0b want 0", busy); end
    w(7); scl = 1'b0;
    w(5); rst_n = 1'b1;
    w(6);
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rm_state: got %0d want %0d", dbg_state, ST_IDLE); end
    st0 = stop_cnt;
    i2c_stop();
    total++; if (stop_cnt - st0 !== 1) begin bad++; $display("FAIL rm_stop_cnt: got %0d want 1", stop_cnt - st0); end
    total++; if (rx_cnt - rx0 !== 0) begin bad++; $display("FAIL rm_no_rx: got %0d want 0", rx_cnt - rx0); end
    exp_q.push_back(8'hAA);
    i2c_start();
    write_byte(8'h02, a);
    write_byte(8'hAA, a);
    total++; if (a !== 1'b1) begin bad++; $display("FAIL rm_ack: got %0b want 1", a); end
    i2c_stop();
    total++; if (rx_cnt - rx0 !== 1) begin bad++; $display("FAIL rm_rx_cnt: got %0d want 1", rx_cnt - rx0); end
    total++; if (rx_data !== 8'hAA) begin bad++; $display("FAIL rm_rx_data: got %02h want aa", rx_data); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_addr_mismatch();
    test_read_nack();
    test_back_to_back();
    test_restart_read();
    test_reset_mid();
    w(10);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rx_leftover: got %0d want 0", exp_q.size()); end
    total++; if (exp_rd_q.size() != 0) begin bad++; $display("FAIL rd_leftover: got %0d want 0", exp_rd_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_target_sync.md
Name: i2c_target_sync

Overview:
- Clocked I2C responder (target) for the existing I2C master.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a fixed 7-bit address, ACKs, and presents write bytes to, and takes read bytes from, a simple byte-stream user interface.
- Open-drain: the block only ever pulls SDA low. No clock stretching.

Parameters:
- TARGET_ADDR, 7'h01, 7-bit address this target responds to.
- SYNC_STAGES, 2, flop stages on scl_in/sda_in before edge detection (min 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- scl_in  input  1  I2C SCL from pad (asynchronous).
- sda_in  input  1  I2C SDA from pad (asynchronous).
- sda_oe  output  1  1 = pull SDA low; 0 = release (pull-up).
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- tx_data  input  8  byte to send on a read; sampled when tx_load pulses.
- tx_load  output  1  one-clk pulse when tx_data is captured.
- busy  output  1  high from an address match until STOP or NACK-terminated read.
- stop_det  output  1  one-clk pulse on every STOP seen on the bus.

Behaviour:

Reset:
- rst_n low asynchronously forces: sda_oe=0, rx_data=0, rx_valid=0, tx_load=0, busy=0, stop_det=0, state=IDLE.
- Synchronizer flops reset to 1 (idle bus).

Sampling and edge detection:
- scl_s/sda_s are the synchronized signals.
- Edges are derived against the previous-clk value.
- START: sda_s falls while scl_s=1. STOP: sda_s rises while scl_s=1.
- START/STOP take priority over any SCL edge in the same clk.
- Bits are sampled on the SCL rise. sda_oe changes only on the SCL fall.
- Reaction latency: SYNC_STAGES+1 clks from a pad edge.
- Requires SCL high and low phases of at least SYNC_STAGES+4 clks.

State machine (bit counter 0..7, shift register MSB-first):
- IDLE: sda_oe=0. START -> ADDR.
- ADDR: shift on 8 SCL rises.
  - After the 8th rise, compare bits[7:1] with TARGET_ADDR and latch rw=bit0.
  - Match: at the next SCL fall set sda_oe=1, busy=1 -> ADDR_ACK.
  - Mismatch -> WAIT_STOP.
- ADDR_ACK: at the next SCL fall:
  - rw=0: sda_oe=0 -> WRITE.
  - rw=1: pulse tx_load, capture tx_data, sda_oe=~tx_data[7] -> READ.
- WRITE: shift on 8 SCL rises.
  - After the 8th rise: rx_data<=byte and rx_valid pulses for 1 clk.
  - Next fall: sda_oe=1 -> WRITE_ACK.
  - An unlimited number of bytes is accepted; each is ACKed.
- WRITE_ACK: next fall: sda_oe=0 -> WRITE.
- READ:
  - Bit 7 is already driven on entry.
  - On each following SCL fall, drive the next bit (sda_oe=~bit).
  - On the fall after bit 0, sda_oe=0 -> READ_ACK.
- READ_ACK: sample the master's bit on the SCL rise.
  - 0 (ACK): at the next fall, tx_load pulse, capture tx_data, drive bit 7 -> READ.
  - 1 (NACK): -> WAIT_STOP, busy=0.
- WAIT_STOP: sda_oe=0. Ignores bits; waits for START or STOP.

Global transitions:
- STOP in any state -> IDLE with sda_oe=0, busy=0, and stop_det pulse. A partial byte is discarded with no rx_valid.
- START in any state (repeated start) -> ADDR with the counter cleared and sda_oe=0. busy holds until the next match or mismatch.
- Reset mid-transfer: sda_oe releases immediately and the block stays in IDLE until a fresh START.

Test Plan:
- Write to addr 0x01 (byte 0x02), data 0xAA, STOP -> sda_oe=1 during both ACK clocks; rx_data=0xAA with exactly one rx_valid pulse; stop_det one pulse; busy back to 0.
- Addr 0x02 write -> sda_oe stays 0 for the whole transfer; no rx_valid; block in WAIT_STOP until STOP.
- Read addr 0x01 (byte 0x03) with tx_data=0x0F, master NACKs -> SDA on bus 0,0,0,0,1,1,1,1; exactly one tx_load; sda_oe=0 during the NACK bit and after.
- Write 0xAA then 0x0F in one transfer -> two rx_valid pulses, rx_data 0xAA then 0x0F, both ACKed.
- Write 0x55, repeated START, read (tx_data=0xC3) with ACK then NACK -> rx_data=0x55; two tx_load pulses; bus bytes 0xC3, 0xC3.
- rst_n low during data bit 4 of a write -> sda_oe=0 within the same clk; no rx_valid; the following full write of 0xAA completes normally.
